// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status into the controller, stage
// register enables/bubbles and mult/div status back out.
//   master : pipeline side (drives hazard sources, receives enables)
//   slave  : pipe_hazard_ctrl
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs_i;
    logic [4:0] id_rt_i;
    logic       id_use_rs_i;
    logic       id_use_rt_i;
    logic       ex_memread_i;
    logic [4:0] ex_wreg_i;
    logic       ex_br_taken_i;
    logic       ex_md_start_i;
    logic       mem_req_i;
    logic       dmem_ready_i;

    logic       pc_we_o;
    logic       ifid_we_o;
    logic       ifid_flush_o;
    logic       idex_we_o;
    logic       idex_flush_o;
    logic       exmem_we_o;
    logic       exmem_flush_o;
    logic       memwb_we_o;
    logic       memwb_flush_o;
    logic       md_busy_o;
    logic       md_done_o;

    modport master (
        output id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i, ex_memread_i,
               ex_wreg_i, ex_br_taken_i, ex_md_start_i, mem_req_i, dmem_ready_i,
        input  pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o, idex_flush_o,
               exmem_we_o, exmem_flush_o, memwb_we_o, memwb_flush_o,
               md_busy_o, md_done_o
    );

    modport slave (
        input  id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i, ex_memread_i,
               ex_wreg_i, ex_br_taken_i, ex_md_start_i, mem_req_i, dmem_ready_i,
        output pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o, idex_flush_o,
               exmem_we_o, exmem_flush_o, memwb_we_o, memwb_flush_o,
               md_busy_o, md_done_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: drives the we/flush pair of
// every stage register plus the PC enable. Resolves data-memory waits,
// multi-cycle mult/div, taken-branch squashes and load-use hazards.
// A stage register zeroes only on we=1 && flush=1, so bubbles are we=1,flush=1.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, active low (outputs forced to the reset pattern)
//   hz    : pipe_hazard_ctrl_if.slave (hazard inputs, enables/status outputs)
// Outputs are combinational from state and inputs.
module pipe_hazard_ctrl #(
    parameter int unsigned MD_LAT = 8,
    parameter int unsigned CW     = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  hz
);

    typedef enum logic [0:0] { RUN = 1'b0, MD_WAIT = 1'b1 } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   md_cnt_q, md_cnt_d;

    logic mem_stall_c;
    logic load_use_c;

    assign mem_stall_c = hz.mem_req_i & ~hz.dmem_ready_i;

    // $zero is never a hazard source
    assign load_use_c = hz.ex_memread_i && (hz.ex_wreg_i != 5'd0) &&
                        ((hz.id_use_rs_i && (hz.id_rs_i == hz.ex_wreg_i)) ||
                         (hz.id_use_rt_i && (hz.id_rt_i == hz.ex_wreg_i)));

    // State and mult/div countdown register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Next state and stage enables, highest-priority hazard first
    always_comb begin
        state_d          = state_q;
        md_cnt_d         = md_cnt_q;
        hz.pc_we_o       = 1'b1;
        hz.ifid_we_o     = 1'b1;
        hz.ifid_flush_o  = 1'b0;
        hz.idex_we_o     = 1'b1;
        hz.idex_flush_o  = 1'b0;
        hz.exmem_we_o    = 1'b1;
        hz.exmem_flush_o = 1'b0;
        hz.memwb_we_o    = 1'b1;
        hz.memwb_flush_o = 1'b0;
        hz.md_busy_o     = (state_q == MD_WAIT);
        hz.md_done_o     = 1'b0;

        if (!rst_n) begin
            hz.pc_we_o       = 1'b0;
            hz.ifid_flush_o  = 1'b1;
            hz.idex_flush_o  = 1'b1;
            hz.exmem_flush_o = 1'b1;
            hz.memwb_flush_o = 1'b1;
            hz.md_busy_o     = 1'b0;
        end else if (mem_stall_c) begin
            // Freeze everything up to MEM; bubble into WB. Counter holds.
            hz.pc_we_o       = 1'b0;
            hz.ifid_we_o     = 1'b0;
            hz.idex_we_o     = 1'b0;
            hz.exmem_we_o    = 1'b0;
            hz.memwb_flush_o = 1'b1;
        end else if ((state_q == MD_WAIT) && (md_cnt_q != '0)) begin
            hz.pc_we_o       = 1'b0;
            hz.ifid_we_o     = 1'b0;
            hz.idex_we_o     = 1'b0;
            hz.exmem_flush_o = 1'b1;
            md_cnt_d         = md_cnt_q - CW'(1);
        end else if ((state_q == RUN) && hz.ex_md_start_i) begin
            // Start cycle counts as the first of MD_LAT EX cycles
            hz.pc_we_o       = 1'b0;
            hz.ifid_we_o     = 1'b0;
            hz.idex_we_o     = 1'b0;
            hz.exmem_flush_o = 1'b1;
            state_d          = MD_WAIT;
            md_cnt_d         = CW'(MD_LAT - 2);
        end else begin
            // RUN, or last mult/div cycle: the deferred branch resolves here
            if (state_q == MD_WAIT) begin
                hz.md_done_o = 1'b1;
                state_d      = RUN;
            end
            if (hz.ex_br_taken_i) begin
                hz.ifid_flush_o = 1'b1;
                hz.idex_flush_o = 1'b1;
            end else if (load_use_c) begin
                hz.pc_we_o      = 1'b0;
                hz.ifid_we_o    = 1'b0;
                hz.idex_flush_o = 1'b1;
            end
        end
    end

endmodule
